// File: rtl/panda_div_pkg.sv
// Shared types and constants for the multi-channel pulse divider.
package panda_div_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StCount = 1'b1
  } state_e;

  localparam logic RouteN = 1'b0;
  localparam logic RouteD = 1'b1;

  localparam int unsigned DefaultCw = 32;

endpackage

// File: rtl/panda_div_chan.sv
// One divider channel: edge detect, first-pulse FSM, pulse counter and routed outputs.
module panda_div_chan
  import panda_div_pkg::*;
#(
  parameter int unsigned Cw = DefaultCw
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inp_i,
  input  logic          enable_i,
  input  logic [Cw-1:0] divisor_i,
  input  logic          first_pulse_i,
  input  logic          force_rst_i,
  output logic          outd_o,
  output logic          outn_o,
  output logic          tc_o,
  output logic [Cw-1:0] count_o
);

  state_e        state_q, state_d;
  logic [Cw-1:0] count_q, count_d;
  logic          route_q, route_d;
  logic          mute_q, mute_d;
  logic          inp_q;
  logic          outd_d, outn_d, tc_d;
  logic          rise;
  logic [Cw-1:0] div_eff, div_m1;

  assign div_eff = (divisor_i == '0) ? Cw'(1) : divisor_i;
  assign div_m1  = div_eff - Cw'(1);
  // inp_q tracks the input even while disabled, so re-enabling mid-level makes no edge.
  assign rise    = inp_i & ~inp_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    route_d = route_q;
    mute_d  = mute_q;
    tc_d    = 1'b0;
    if (!enable_i || force_rst_i) begin
      // Muting suppresses any high level already in progress until a fresh edge.
      state_d = StIdle;
      count_d = '0;
      mute_d  = 1'b1;
    end else if (rise) begin
      mute_d  = 1'b0;
      state_d = StCount;
      if (state_q == StIdle) begin
        if (first_pulse_i || (div_eff == Cw'(1))) begin
          route_d = RouteD;
          count_d = '0;
        end else begin
          route_d = RouteN;
          count_d = Cw'(1);
        end
      end else if (count_q >= div_m1) begin
        // >= lets a divisor lowered mid-count take effect on the next pulse.
        route_d = RouteD;
        count_d = '0;
      end else begin
        route_d = RouteN;
        count_d = count_q + Cw'(1);
      end
      tc_d = (route_d == RouteD);
    end
    outd_d = inp_i & route_d & ~mute_d;
    outn_d = inp_i & ~route_d & ~mute_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      route_q <= RouteN;
      mute_q  <= 1'b0;
      inp_q   <= 1'b0;
      outd_o  <= 1'b0;
      outn_o  <= 1'b0;
      tc_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      route_q <= route_d;
      mute_q  <= mute_d;
      inp_q   <= inp_i;
      outd_o  <= outd_d;
      outn_o  <= outn_d;
      tc_o    <= tc_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/panda_div_multi.sv
// Multi-channel pulse divider: slices the flat configuration buses across independent channels.
module panda_div_multi
  import panda_div_pkg::*;
#(
  parameter int unsigned NCHAN = 4,
  parameter int unsigned CW    = DefaultCw
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NCHAN-1:0]    inp_i,
  input  logic [NCHAN-1:0]    enable_i,
  input  logic [NCHAN*CW-1:0] DIVISOR,
  input  logic [NCHAN-1:0]    FIRST_PULSE,
  input  logic [NCHAN-1:0]    FORCE_RST,
  output logic [NCHAN-1:0]    outd_o,
  output logic [NCHAN-1:0]    outn_o,
  output logic [NCHAN-1:0]    tc_o,
  output logic [NCHAN*CW-1:0] COUNT
);

  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    panda_div_chan #(
      .Cw(CW)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_n_i),
      .inp_i        (inp_i[k]),
      .enable_i     (enable_i[k]),
      .divisor_i    (DIVISOR[k*CW +: CW]),
      .first_pulse_i(FIRST_PULSE[k]),
      .force_rst_i  (FORCE_RST[k]),
      .outd_o       (outd_o[k]),
      .outn_o       (outn_o[k]),
      .tc_o         (tc_o[k]),
      .count_o      (COUNT[k*CW +: CW])
    );
  end

endmodule

// File: tb/tb_panda_div_multi.sv
// Scoreboard bench: stimulus pushes expected routing per pulse, a monitor pops on each output edge.
module tb_panda_div_multi;

  localparam int NCHAN = 4;
  localparam int CW    = 32;

  typedef struct {
    logic        d;
    logic [31:0] cnt;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCHAN-1:0]    inp, enable, first_pulse, force_rst;
  logic [NCHAN*CW-1:0] divisor;
  logic [NCHAN-1:0]    outd, outn, tc;
  logic [NCHAN*CW-1:0] count;

  exp_t exp_q[NCHAN][$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  panda_div_multi #(
    .NCHAN(NCHAN),
    .CW   (CW)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .inp_i      (inp),
    .enable_i   (enable),
    .DIVISOR    (divisor),
    .FIRST_PULSE(first_pulse),
    .FORCE_RST  (force_rst),
    .outd_o     (outd),
    .outn_o     (outn),
    .tc_o       (tc),
    .COUNT      (count)
  );

  task automatic chk(input string name, input int ch, input logic [127:0] act,
                     input logic [127:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s ch%0d: got %0h, expected %0h at %0t", name, ch, act, expv, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic d, input int cnt);
    exp_t e;
    e.d   = d;
    e.cnt = cnt;
    exp_q[ch].push_back(e);
  endtask

  task automatic pulse(input logic [NCHAN-1:0] mask, input int hi, input int lo);
    inp = mask;
    cyc(hi);
    inp = '0;
    cyc(lo);
  endtask

  task automatic rearm(input logic [NCHAN-1:0] mask);
    force_rst = mask;
    cyc(1);
    force_rst = '0;
    cyc(1);
  endtask

  // Monitor: each rising output level on a channel is one routed pulse.
  initial begin
    logic [NCHAN-1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int ch = 0; ch < NCHAN; ch++) begin
          if ((outd[ch] | outn[ch]) && !prev[ch]) begin
            if (exp_q[ch].size() == 0) begin
              chk("unexpected_pulse", ch, {outd[ch], outn[ch]}, 2'b00);
            end else begin
              e = exp_q[ch].pop_front();
              chk("route", ch, {outd[ch], outn[ch]}, {e.d, ~e.d});
              chk("tc", ch, tc[ch], e.d);
              chk("count", ch, count[ch*CW +: CW], e.cnt);
            end
          end else if (tc[ch]) begin
            chk("stray_tc", ch, tc[ch], 1'b0);
          end
        end
      end
      prev = outd | outn;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    inp         = '0;
    enable      = 4'b0001;
    first_pulse = '0;
    force_rst   = '0;
    divisor     = '0;
    #12;
    chk("reset_outd", 0, outd, '0);
    chk("reset_outn", 0, outn, '0);
    chk("reset_tc", 0, tc, '0);
    chk("reset_count", 0, count, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2);

    // DIVISOR=3, FIRST_PULSE=0: N,N,D repeating, COUNT 1,2,0
    divisor[0*CW +: CW] = 3;
    for (int i = 0; i < 9; i++) begin
      push(0, (i % 3) == 2, ((i % 3) == 2) ? 0 : (i % 3) + 1);
      pulse(4'b0001, 2, 2);
    end

    // DIVISOR=3, FIRST_PULSE=1: D,N,N,D; 5-cycle pulse lags by one clock
    first_pulse = 4'b0001;
    rearm(4'b0001);
    push(0, 1'b1, 0);
    inp = 4'b0001;
    #2;
    chk("lag_before", 0, outd[0], 1'b0);
    @(posedge clk);
    #1;
    for (int j = 1; j <= 5; j++) begin
      #2;
      chk("width_high", 0, outd[0], 1'b1);
      @(posedge clk);
      #1;
      if (j == 4) inp = '0;
    end
    #2;
    chk("width_end", 0, outd[0], 1'b0);
    cyc(2);
    push(0, 1'b0, 1);
    pulse(4'b0001, 2, 2);
    push(0, 1'b0, 2);
    pulse(4'b0001, 2, 2);
    push(0, 1'b1, 0);
    pulse(4'b0001, 2, 2);

    // DIVISOR=0 then 1: every pulse to outd
    first_pulse = '0;
    divisor[0*CW +: CW] = 0;
    rearm(4'b0001);
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b1, 0);
      pulse(4'b0001, 1, 2);
    end
    divisor[0*CW +: CW] = 1;
    rearm(4'b0001);
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b1, 0);
      pulse(4'b0001, 3, 2);
    end

    // DIVISOR=5 lowered to 2 after COUNT=3
    divisor[0*CW +: CW] = 5;
    rearm(4'b0001);
    for (int i = 1; i <= 3; i++) begin
      push(0, 1'b0, i);
      pulse(4'b0001, 2, 2);
    end
    divisor[0*CW +: CW] = 2;
    push(0, 1'b1, 0);
    pulse(4'b0001, 2, 2);

    // FORCE_RST mid-pulse at COUNT=2, then coincident with a rise
    divisor[0*CW +: CW] = 4;
    rearm(4'b0001);
    push(0, 1'b0, 1);
    pulse(4'b0001, 2, 2);
    push(0, 1'b0, 2);
    inp = 4'b0001;
    cyc(2);
    chk("count_before_force", 0, count[0*CW +: CW], 2);
    force_rst = 4'b0001;
    cyc(1);
    force_rst = '0;
    #1;
    chk("force_outn", 0, outn[0], 1'b0);
    chk("force_count", 0, count[0*CW +: CW], 0);
    cyc(1);
    #1;
    chk("force_suppress", 0, outn[0] | outd[0], 1'b0);
    inp = '0;
    cyc(2);
    inp = 4'b0001;
    force_rst = 4'b0001;
    cyc(1);
    force_rst = '0;
    #1;
    chk("force_rise_out", 0, outn[0] | outd[0], 1'b0);
    chk("force_rise_tc", 0, tc[0], 1'b0);
    cyc(1);
    #1;
    chk("force_rise_hold", 0, outn[0] | outd[0], 1'b0);
    inp = '0;
    cyc(2);
    push(0, 1'b0, 1);
    pulse(4'b0001, 2, 2);
    push(0, 1'b0, 2);
    pulse(4'b0001, 2, 2);

    // Four channels on a shared train, ch1 disabled, async reset mid-pulse
    enable = 4'b1101;
    divisor[0*CW +: CW] = 2;
    divisor[1*CW +: CW] = 3;
    divisor[2*CW +: CW] = 1;
    divisor[3*CW +: CW] = 7;
    rearm(4'hF);
    for (int i = 0; i < 8; i++) begin
      push(0, (i % 2) == 1, ((i % 2) == 1) ? 0 : 1);
      push(2, 1'b1, 0);
      push(3, i == 6, (i == 6) ? 0 : ((i < 6) ? i + 1 : i - 6));
      pulse(4'hF, 1, 2);
    end
    chk("disabled_count", 1, count[1*CW +: CW], 0);
    push(0, 1'b0, 1);
    push(2, 1'b1, 0);
    push(3, 1'b0, 2);
    inp = 4'hF;
    cyc(2);
    #1;
    rst_n = 1'b0;
    inp   = '0;
    #1;
    chk("async_outd", 0, outd, '0);
    chk("async_outn", 0, outn, '0);
    chk("async_tc", 0, tc, '0);
    chk("async_count", 0, count, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(3);

    for (int ch = 0; ch < NCHAN; ch++) begin
      chk("leftover_expected", ch, exp_q[ch].size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/panda_div_multi.md
Name: panda_div_multi

Overview:
- Parametrised, multi-channel successor to the single-channel pulse divider.
- Each channel counts rising edges on its input. Every DIVISOR-th pulse is routed to outd; all other pulses are routed to outn.
- Adds per-channel enable gating, an explicit first-pulse state machine, defined DIVISOR=0 handling, and a per-channel terminal-count strobe.
- Sits in the position-bus/bit-bus fabric. Configuration comes from register block fields; outputs feed back onto the bit bus.

Parameters:
- NCHAN, 4, number of independent divider channels (1..16).
- CW, 32, width of the divisor and count per channel (8..32).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- inp_i  in  NCHAN  per-channel pulse input, synchronous to clk_i.
- enable_i  in  NCHAN  per-channel gate; low holds the channel idle.
- DIVISOR  in  NCHAN*CW  per-channel divisor; channel k occupies bits [k*CW +: CW].
- FIRST_PULSE  in  NCHAN  1 = first pulse after arming goes to outd; 0 = first pulse goes to outn.
- FORCE_RST  in  NCHAN  synchronous one-cycle strobe; re-arms the channel.
- outd_o  out  NCHAN  divided output (pulse level follows inp).
- outn_o  out  NCHAN  non-divided remainder output.
- tc_o  out  NCHAN  one-cycle strobe, asserted with each pulse routed to outd.
- COUNT  out  NCHAN*CW  per-channel count of pulses since the last outd pulse.

Behaviour:
- Reset (rst_n_i low, async):
  - all outputs 0, COUNT 0, every channel in state IDLE, route register 0, input delay register 0.
- Effective divisor:
  - div_eff = (DIVISOR==0) ? 1 : DIVISOR.
  - With div_eff = 1, every pulse goes to outd.
- Edge detection:
  - rise = inp_i & ~inp_d, where inp_d is inp_i registered.
- States: IDLE, COUNT.
  - IDLE, on rise:
    - FIRST_PULSE=1 or div_eff==1: route=D, COUNT<=0.
    - Otherwise: route=N, COUNT<=1 (but if div_eff==2 and FIRST_PULSE=0, still COUNT<=1). State -> COUNT.
  - COUNT, on rise:
    - COUNT >= div_eff-1: route=D, COUNT<=0.
    - Otherwise: route=N, COUNT<=COUNT+1.
  - The >= comparison makes a divisor lowered mid-count take effect on the next pulse; no wrap past div_eff.
- Outputs (registered, 1-cycle latency from inp_i):
  - outd_o <= inp_i & sel_d; outn_o <= inp_i & ~sel_d.
  - sel_d is the route decided this cycle on rise, otherwise the held route.
  - A pulse is never split between outputs.
  - tc_o <= rise & (decision==D).
- Simultaneous events in one cycle:
  - FORCE_RST: COUNT<=0, state->IDLE, outd_o/outn_o<=0. This persists until the next rise; an in-progress high input level is suppressed. A rise in the same cycle is discarded.
  - enable_i low: same effect as FORCE_RST, held for as long as enable is low. No pulses are routed while low.
  - enable_i rising while inp_i is already high: no rise is generated, because inp_d keeps tracking inp_i while disabled. Output stays low until the next true rising edge.
  - Priority: rst_n_i > enable_i low > FORCE_RST > rise.
- COUNT:
  - Registered; updates the cycle after rise (same cycle as outputs).
  - Width CW; no overflow is possible because COUNT <= div_eff-1.
- Channels are fully independent. No cross-channel state.

Decomposition:
- Package panda_div_pkg:
  - state encoding (IDLE=1'b0, COUNT=1'b1);
  - route constants (ROUTE_N=0, ROUTE_D=1);
  - default CW.
- Sub-module panda_div_chan: one channel (edge detect, FSM, counter, output registers). It is parametrised by CW and instantiated NCHAN times in a generate loop.
- The top level only slices the flat buses.

Test Plan:
- DIVISOR=3, FIRST_PULSE=0, 9 input pulses on ch0 -> outn,outn,outd repeated 3 times; tc_o on pulses 3,6,9; COUNT sequence 1,2,0,1,2,0,...
- DIVISOR=3, FIRST_PULSE=1, 4 pulses -> outd,outn,outn,outd; COUNT 0,1,2,0. Outputs lag inp_i by exactly 1 clock and match its high width (e.g. 5 cycles).
- DIVISOR=0 and DIVISOR=1 -> every pulse on outd, tc_o on every pulse, outn_o never asserted, COUNT stays 0.
- DIVISOR=5, pulses 1..3 routed to outn (COUNT=3), then DIVISOR changed to 2 -> next pulse goes to outd and COUNT=0.
- FORCE_RST asserted mid-pulse at COUNT=2 (DIVISOR=4) -> output drops low next cycle and COUNT=0. Then FORCE_RST coincident with a rise -> that edge is ignored, and the next edge is treated as the first pulse.
- NCHAN=4: ch0 DIVISOR=2, ch3 DIVISOR=7, enable_i[1]=0, shared pulse train; rst_n_i pulled low mid-pulse -> channels divide independently, ch1 outputs stay 0, and all outputs and COUNT clear to 0 asynchronously without waiting for a clock edge.
